// File: rtl/rv_ctrl_pkg.sv
// Shared constants for the RV32I upstream control stage: instruction types,
// opcodes, control-word field positions and the canonical NOP encodings.
package rv_ctrl_pkg;

   localparam logic [3:0] T_LOAD   = 4'd0;
   localparam logic [3:0] T_IMM    = 4'd1;
   localparam logic [3:0] T_STORE  = 4'd2;
   localparam logic [3:0] T_REG    = 4'd3;
   localparam logic [3:0] T_LUI    = 4'd4;
   localparam logic [3:0] T_AUIPC  = 4'd5;
   localparam logic [3:0] T_BRANCH = 4'd6;
   localparam logic [3:0] T_JALR   = 4'd7;
   localparam logic [3:0] T_JAL    = 4'd8;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam int CW_TYPE_LSB = 0;
   localparam int CW_FUN3_LSB = 4;
   localparam int CW_FUN7     = 7;
   localparam int CW_RD_LSB   = 8;
   localparam int CW_RS1_LSB  = 13;
   localparam int CW_RS2_LSB  = 18;

   localparam logic [22:0] NOP_CWORD = 23'h000001;
   localparam logic [31:0] NOP_INSTR = 32'h00000013;

   function automatic logic [3:0] cw_type(input logic [22:0] cw);
      return cw[CW_TYPE_LSB +: 4];
   endfunction

   function automatic logic [2:0] cw_fun3(input logic [22:0] cw);
      return cw[CW_FUN3_LSB +: 3];
   endfunction

   function automatic logic [4:0] cw_rd(input logic [22:0] cw);
      return cw[CW_RD_LSB +: 5];
   endfunction

   function automatic logic [4:0] cw_rs1(input logic [22:0] cw);
      return cw[CW_RS1_LSB +: 5];
   endfunction

   function automatic logic [4:0] cw_rs2(input logic [22:0] cw);
      return cw[CW_RS2_LSB +: 5];
   endfunction

   // True when a stage holding this word will write a nonzero register.
   function automatic logic writes_rd(input logic [22:0] cw);
      return (cw_type(cw) != T_STORE) && (cw_type(cw) != T_BRANCH) &&
             (cw_rd(cw) != 5'd0);
   endfunction

endpackage

// File: rtl/rv_decoder.sv
// Combinational RV32I decoder: instruction word to 23-bit control word and
// sign-extended immediate. Unknown opcodes decode as NOP with a zero immediate.
module rv_decoder
   import rv_ctrl_pkg::*;
(
   input  logic [31:0] instr_i,
   output logic [22:0] cword_o,
   output logic [31:0] imm_o
);

   logic [6:0]  opcode;
   logic [2:0]  fun3;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [3:0]  itype;
   logic        known, use_rs1, use_rs2, use_rd, fun7;
   logic [31:0] imm_sel;

   assign opcode = instr_i[6:0];
   assign fun3   = instr_i[14:12];

   assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
   assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
   assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                   instr_i[11:8], 1'b0};
   assign imm_u = {instr_i[31:12], 12'h000};
   assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                   instr_i[30:21], 1'b0};

   always_comb begin
      itype   = T_IMM;
      known   = 1'b1;
      use_rs1 = 1'b1;
      use_rs2 = 1'b1;
      use_rd  = 1'b1;
      fun7    = 1'b0;
      imm_sel = 32'h0;
      case (opcode)
         OP_LOAD:   begin itype = T_LOAD;   use_rs2 = 1'b0; imm_sel = imm_i; end
         OP_IMM:    begin
            itype   = T_IMM;
            use_rs2 = 1'b0;
            imm_sel = imm_i;
            fun7    = (fun3 == 3'b101) && instr_i[30];
         end
         OP_STORE:  begin itype = T_STORE;  use_rd = 1'b0;  imm_sel = imm_s; end
         OP_REG:    begin itype = T_REG;    fun7 = instr_i[30]; end
         OP_LUI:    begin itype = T_LUI;    use_rs1 = 1'b0; use_rs2 = 1'b0; imm_sel = imm_u; end
         OP_AUIPC:  begin itype = T_AUIPC;  use_rs1 = 1'b0; use_rs2 = 1'b0; imm_sel = imm_u; end
         OP_BRANCH: begin itype = T_BRANCH; use_rd = 1'b0;  imm_sel = imm_b; end
         OP_JALR:   begin itype = T_JALR;   use_rs2 = 1'b0; imm_sel = imm_i; end
         OP_JAL:    begin itype = T_JAL;    use_rs1 = 1'b0; use_rs2 = 1'b0; imm_sel = imm_j; end
         default:   known = 1'b0;
      endcase

      cword_o = NOP_CWORD;
      imm_o   = 32'h0;
      if (known) begin
         cword_o = {instr_i[24:20] & {5{use_rs2}},
                    instr_i[19:15] & {5{use_rs1}},
                    instr_i[11:7]  & {5{use_rd}},
                    fun7, fun3, itype};
         imm_o   = imm_sel;
      end
   end

endmodule

// File: rtl/rv_pipe_ctrl.sv
// Upstream control for the RV32I pipeline: PC/fetch, IF/ID register, control
// word pipeline, branch/jump redirect and RAW-hazard stalls (no forwarding).
module rv_pipe_ctrl
   import rv_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
)(
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_data,
   input  logic [31:0] r_for_pc,
   input  logic [3:0]  funit_ZCNVFlags,
   output logic [22:0] cwordID,
   output logic [22:0] cwordEX,
   output logic [22:0] cwordMEM,
   output logic [22:0] cwordWB,
   output logic [31:0] pc,
   output logic [31:0] immEX,
   output logic [31:0] immMEM,
   output logic        stall,
   output logic        flush
);

   logic [31:0] pc_q, pc_d, instr_q, instr_d, pcid_q, pcid_d;
   logic [22:0] cw_ex_q, cw_ex_d, cw_mem_q, cw_mem_d, cw_wb_q, cw_wb_d;
   logic [31:0] pc_ex_q, pc_ex_d, imm_ex_q, imm_ex_d, imm_mem_q, imm_mem_d;
   logic [22:0] cw_id;
   logic [31:0] imm_id, br_tgt, jump_tgt;
   logic        flag_z, flag_c, flag_n, flag_v, br_cond, br_taken, is_jump;

   rv_decoder u_dec (
      .instr_i (instr_q),
      .cword_o (cw_id),
      .imm_o   (imm_id)
   );

   function automatic logic hit(input logic [22:0] stage_cw, input logic [4:0] rs);
      return (rs != 5'd0) && writes_rd(stage_cw) && (cw_rd(stage_cw) == rs);
   endfunction

   assign stall = hit(cw_ex_q,  cw_rs1(cw_id)) || hit(cw_ex_q,  cw_rs2(cw_id)) ||
                  hit(cw_mem_q, cw_rs1(cw_id)) || hit(cw_mem_q, cw_rs2(cw_id)) ||
                  hit(cw_wb_q,  cw_rs1(cw_id)) || hit(cw_wb_q,  cw_rs2(cw_id));

   assign {flag_z, flag_c, flag_n, flag_v} = funit_ZCNVFlags;

   always_comb begin
      case (cw_fun3(cw_ex_q))
         3'b000:  br_cond = flag_z;
         3'b001:  br_cond = !flag_z;
         3'b100:  br_cond = flag_n ^ flag_v;
         3'b101:  br_cond = !(flag_n ^ flag_v);
         3'b110:  br_cond = !flag_c;
         3'b111:  br_cond = flag_c;
         default: br_cond = 1'b0;
      endcase
   end

   assign br_taken = (cw_type(cw_ex_q) == T_BRANCH) && br_cond;
   assign br_tgt   = pc_ex_q + imm_ex_q;
   assign is_jump  = (cw_type(cw_id) == T_JAL) || (cw_type(cw_id) == T_JALR);
   assign jump_tgt = (cw_type(cw_id) == T_JAL) ? (pcid_q + imm_id)
                                               : ((r_for_pc + imm_id) & ~32'h1);
   assign flush    = br_taken;

   // A taken branch outranks a stall, which outranks a jump in ID.
   always_comb begin
      pc_d      = pc_q + 32'd4;
      instr_d   = imem_data;
      pcid_d    = pc_q;
      cw_ex_d   = cw_id;
      pc_ex_d   = pcid_q;
      imm_ex_d  = imm_id;
      cw_mem_d  = cw_ex_q;
      cw_wb_d   = cw_mem_q;
      imm_mem_d = imm_ex_q;
      if (br_taken) begin
         pc_d     = br_tgt;
         instr_d  = NOP_INSTR;
         pcid_d   = pcid_q;
         cw_ex_d  = NOP_CWORD;
         pc_ex_d  = pc_ex_q;
         imm_ex_d = 32'h0;
      end else if (stall) begin
         pc_d     = pc_q;
         instr_d  = instr_q;
         pcid_d   = pcid_q;
         cw_ex_d  = NOP_CWORD;
         pc_ex_d  = pc_ex_q;
         imm_ex_d = 32'h0;
      end else if (is_jump) begin
         pc_d    = jump_tgt;
         instr_d = NOP_INSTR;
         pcid_d  = pcid_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q      <= RESET_PC;
         instr_q   <= NOP_INSTR;
         pcid_q    <= 32'h0;
         cw_ex_q   <= NOP_CWORD;
         cw_mem_q  <= NOP_CWORD;
         cw_wb_q   <= NOP_CWORD;
         pc_ex_q   <= 32'h0;
         imm_ex_q  <= 32'h0;
         imm_mem_q <= 32'h0;
      end else begin
         pc_q      <= pc_d;
         instr_q   <= instr_d;
         pcid_q    <= pcid_d;
         cw_ex_q   <= cw_ex_d;
         cw_mem_q  <= cw_mem_d;
         cw_wb_q   <= cw_wb_d;
         pc_ex_q   <= pc_ex_d;
         imm_ex_q  <= imm_ex_d;
         imm_mem_q <= imm_mem_d;
      end
   end

   assign imem_addr = pc_q;
   assign cwordID   = cw_id;
   assign cwordEX   = cw_ex_q;
   assign cwordMEM  = cw_mem_q;
   assign cwordWB   = cw_wb_q;
   assign pc        = pc_ex_q;
   assign immEX     = imm_ex_q;
   assign immMEM    = imm_mem_q;

endmodule

// File: tb/tb_rv_pipe_ctrl.sv
// Directed bench for rv_pipe_ctrl: small instruction memory, hand-computed
// expected values for decode, stalls, branches, jumps and async reset.
module tb_rv_pipe_ctrl;

   logic        clk;
   logic        rst;
   logic [31:0] imem_addr, imem_data, r_for_pc;
   logic [3:0]  flags;
   logic [22:0] cwordID, cwordEX, cwordMEM, cwordWB;
   logic [31:0] pc, immEX, immMEM;
   logic        stall, flush;

   logic [31:0] imem [0:63];
   int          n_tests;
   int          n_fail;

   localparam logic [31:0] NOP_I  = 32'h00000013;
   localparam logic [31:0] NOP_CW = 32'h00000001;

   assign imem_data = imem[imem_addr[7:2]];

   rv_pipe_ctrl #(.RESET_PC(32'h0000_0000)) dut (
      .clk             (clk),
      .rst             (rst),
      .imem_addr       (imem_addr),
      .imem_data       (imem_data),
      .r_for_pc        (r_for_pc),
      .funit_ZCNVFlags (flags),
      .cwordID         (cwordID),
      .cwordEX         (cwordEX),
      .cwordMEM        (cwordMEM),
      .cwordWB         (cwordWB),
      .pc              (pc),
      .immEX           (immEX),
      .immMEM          (immMEM),
      .stall           (stall),
      .flush           (flush)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic load_nops();
      for (int i = 0; i < 64; i++) imem[i] = NOP_I;
   endtask

   // Holds reset for two cycles and releases it on a falling edge.
   task automatic do_reset();
      rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Branch vectors: fun3, ZCNV flags, expected taken.
   int bf3 [10] = '{0, 0, 1, 4, 4, 5, 6, 6, 7, 2};
   int bfl [10] = '{8, 0, 0, 2, 3, 3, 4, 0, 4, 15};
   int btk [10] = '{1, 0, 1, 1, 0, 1, 0, 1, 1, 0};

   initial begin
      n_tests  = 0;
      n_fail   = 0;
      rst      = 1'b0;
      flags    = 4'h0;
      r_for_pc = 32'h101;
      load_nops();

      // Reset state
      @(negedge clk);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_cwid", {9'h0, cwordID}, NOP_CW);
      chk("rst_cwex", {9'h0, cwordEX}, NOP_CW);
      chk("rst_pc", pc, 32'h0);
      chk("rst_immex", immEX, 32'h0);
      chk("rst_stall", {31'h0, stall}, 32'h0);

      // Decode: add x3,x1,x2 then srai x4,x1,5
      imem[0] = 32'h002081B3;
      imem[1] = 32'h4050D213;
      do_reset();
      step(1);
      chk("dec_add", {9'h0, cwordID}, 32'h082303);
      chk("dec_add_stall", {31'h0, stall}, 32'h0);
      step(1);
      chk("dec_srai", {9'h0, cwordID}, 32'h0024D1);
      chk("dec_add_ex", {9'h0, cwordEX}, 32'h082303);
      step(1);
      chk("dec_srai_ex", {9'h0, cwordEX}, 32'h0024D1);
      chk("dec_srai_imm", immEX, 32'h405);
      chk("dec_srai_pc", pc, 32'h4);
      chk("dec_immmem", immMEM, 32'h0);

      // Async reset between edges, no clock edge required
      #2 rst = 1'b0;
      #1;
      chk("arst_addr", imem_addr, 32'h0);
      chk("arst_cwex", {9'h0, cwordEX}, NOP_CW);
      chk("arst_cwmem", {9'h0, cwordMEM}, NOP_CW);
      chk("arst_cwwb", {9'h0, cwordWB}, NOP_CW);
      @(negedge clk);
      rst = 1'b1;

      // Load-use: lw x5,0(x1); add x6,x5,x5
      load_nops();
      imem[0] = 32'h0000A283;
      imem[1] = 32'h00528333;
      do_reset();
      step(2);
      chk("lu_stall1", {31'h0, stall}, 32'h1);
      chk("lu_addr1", imem_addr, 32'h8);
      step(1);
      chk("lu_stall2", {31'h0, stall}, 32'h1);
      chk("lu_cwex2", {9'h0, cwordEX}, NOP_CW);
      chk("lu_addr2", imem_addr, 32'h8);
      step(1);
      chk("lu_stall3", {31'h0, stall}, 32'h1);
      chk("lu_cwex3", {9'h0, cwordEX}, NOP_CW);
      step(1);
      chk("lu_stall4", {31'h0, stall}, 32'h0);
      chk("lu_addr4", imem_addr, 32'h8);
      step(1);
      chk("lu_add_ex", {9'h0, cwordEX}, 32'h14A603);
      chk("lu_addr5", imem_addr, 32'hC);

      // Branch table: branch at 0x20 with offset +16
      for (int i = 0; i < 10; i++) begin
         load_nops();
         imem[8] = 32'h00000863 | (32'(bf3[i]) << 12);
         flags   = 4'(bfl[i]);
         do_reset();
         step(10);
         chk("br_pc", pc, 32'h20);
         chk("br_immex", immEX, 32'h10);
         chk("br_flush", {31'h0, flush}, 32'(btk[i]));
         step(1);
         chk("br_next_addr", imem_addr, (btk[i] != 0) ? 32'h30 : 32'h2C);
         if (btk[i] != 0) begin
            chk("br_cwid_nop", {9'h0, cwordID}, NOP_CW);
            chk("br_cwex_nop", {9'h0, cwordEX}, NOP_CW);
            chk("br_flush_after", {31'h0, flush}, 32'h0);
         end
      end
      flags = 4'h0;

      // jalr x1,8(x2) with rs1 data 0x101
      load_nops();
      imem[0] = 32'h008100E7;
      do_reset();
      step(1);
      chk("jalr_stall", {31'h0, stall}, 32'h0);
      step(1);
      chk("jalr_addr", imem_addr, 32'h108);
      chk("jalr_cwid", {9'h0, cwordID}, NOP_CW);
      chk("jalr_cwex", {9'h0, cwordEX}, 32'h004107);
      chk("jalr_immex", immEX, 32'h8);

      // jal x0,-8 at 0x40
      load_nops();
      imem[16] = 32'hFF9FF06F;
      do_reset();
      step(17);
      chk("jal_type", {28'h0, cwordID[3:0]}, 32'h8);
      step(1);
      chk("jal_addr", imem_addr, 32'h38);
      chk("jal_pc", pc, 32'h40);
      chk("jal_immex", immEX, 32'hFFFFFFF8);
      chk("jal_cwid", {9'h0, cwordID}, NOP_CW);

      // Priority: taken beq in EX while a stalled jalr waits in ID
      load_nops();
      imem[0] = 32'h00100113;
      imem[1] = 32'h00000863;
      imem[2] = 32'h008100E7;
      flags   = 4'h8;
      do_reset();
      step(3);
      chk("pri_stall", {31'h0, stall}, 32'h1);
      chk("pri_flush", {31'h0, flush}, 32'h1);
      step(1);
      chk("pri_addr", imem_addr, 32'h14);
      chk("pri_cwid", {9'h0, cwordID}, NOP_CW);
      chk("pri_cwex", {9'h0, cwordEX}, NOP_CW);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
